// File: rtl/rca_serial_ctrl.sv
// Word-serial sequencer around a WIDTH-bit ripple-carry slice: chains the slice carry
// across the words of a packet. Optional signed overflow output: define RCA_SERIAL_OVF_EN.
module rca_serial_ctrl #(
    parameter int WIDTH     = 3,
    parameter int MAX_WORDS = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [WIDTH-1:0]                   i_a,
    input  logic [WIDTH-1:0]                   i_b,
    input  logic                               i_c,
    input  logic                               i_last,
    output logic [WIDTH-1:0]                   o_add_a,
    output logic [WIDTH-1:0]                   o_add_b,
    output logic                               o_add_c,
    input  logic [WIDTH-1:0]                   i_add_sum,
    input  logic                               i_add_c,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [WIDTH-1:0]                   o_sum,
    output logic                               o_last,
    output logic                               o_cout,
    output logic                               o_trunc,
`ifdef RCA_SERIAL_OVF_EN
    output logic                               o_ovf,
`endif
    output logic [$clog2(MAX_WORDS+1)-1:0]     o_words
);

    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_valid;
    logic [WIDTH-1:0] r_sum;
    logic            r_last;
    logic            r_cout;
    logic            r_trunc;
    logic            r_carry;
    logic [CW-1:0]   r_words;

    logic            w_accept;
    logic            w_xfer;
    logic            w_force;
    logic            w_is_last;
    logic [CW-1:0]   w_words_nxt;

`ifdef RCA_SERIAL_OVF_EN
    logic            r_ovf;

    function automatic logic ovf_f(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign o_ovf = r_ovf;
`endif

    // One-deep output buffer: a word may enter whenever the current one leaves.
    assign o_ready  = !r_valid || i_ready;
    assign w_accept = i_valid && o_ready;
    assign w_xfer   = r_valid && i_ready;

    assign o_add_a  = i_a;
    assign o_add_b  = i_b;
    assign o_valid  = r_valid;
    assign o_sum    = r_sum;
    assign o_last   = r_last;
    assign o_cout   = r_cout;
    assign o_trunc  = r_trunc;
    assign o_words  = r_words;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FIRST: begin
                if (w_accept && !w_is_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_FIRST;
                end
            end
            ST_RUN: begin
                if (w_accept && w_is_last) begin
                    w_state_nxt = ST_FIRST;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_FIRST;
        endcase
    end

    // Slice carry-in select and beat classification; FIRST masks the stale carry.
    always_comb begin
        o_add_c     = i_c;
        w_words_nxt = {{(CW-1){1'b0}}, 1'b1};
        case (r_state)
            ST_FIRST: begin
                o_add_c     = i_c;
                w_words_nxt = {{(CW-1){1'b0}}, 1'b1};
            end
            ST_RUN: begin
                o_add_c     = r_carry;
                w_words_nxt = r_words + {{(CW-1){1'b0}}, 1'b1};
            end
            default: begin
                o_add_c     = i_c;
                w_words_nxt = {{(CW-1){1'b0}}, 1'b1};
            end
        endcase
        w_force   = (r_state == ST_RUN) && !i_last && (w_words_nxt == CW'(MAX_WORDS));
        w_is_last = i_last || w_force;
    end

    // Output buffer and carry register; accept takes priority over a plain drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_sum   <= {WIDTH{1'b0}};
            r_last  <= 1'b0;
            r_cout  <= 1'b0;
            r_trunc <= 1'b0;
            r_carry <= 1'b0;
            r_words <= {CW{1'b0}};
`ifdef RCA_SERIAL_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_sum   <= i_add_sum;
            r_last  <= w_is_last;
            r_cout  <= w_is_last && i_add_c;
            r_trunc <= w_force;
            r_carry <= i_add_c;
            r_words <= w_words_nxt;
`ifdef RCA_SERIAL_OVF_EN
            r_ovf   <= w_is_last && ovf_f(i_a, i_b, i_add_sum);
`endif
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rca_serial_ctrl.sv
// Self-checking bench for rca_serial_ctrl: directed vector table, multi-cycle corner
// sequences and random packets, checked through an integer-model scoreboard.
module tb_rca_serial_ctrl;

    localparam int WIDTH     = 3;
    localparam int MAX_WORDS = 16;
    localparam int CW        = 5;

    logic             clk = 1'b0;
    logic             i_rst, i_valid, o_ready, i_c, i_last;
    logic [WIDTH-1:0] i_a, i_b, add_a, add_b, add_sum, o_sum;
    logic             add_c, add_co, o_valid, i_ready, o_last, o_cout, o_trunc;
    logic [CW-1:0]    o_words;
    logic [3:0]       slice_full;
`ifdef RCA_SERIAL_OVF_EN
    logic             o_ovf;
`endif

    always #5 clk = ~clk;

    // Bench-side 3-bit ripple-carry slice.
    assign slice_full = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_c};
    assign add_sum    = slice_full[2:0];
    assign add_co     = slice_full[3];

    rca_serial_ctrl #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_last(i_last),
        .o_add_a(add_a), .o_add_b(add_b), .o_add_c(add_c),
        .i_add_sum(add_sum), .i_add_c(add_co),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_last(o_last),
        .o_cout(o_cout), .o_trunc(o_trunc),
`ifdef RCA_SERIAL_OVF_EN
        .o_ovf(o_ovf),
`endif
        .o_words(o_words)
    );

    typedef struct {
        logic [2:0] sum;
        logic       last;
        logic       cout;
        logic       trunc;
        logic [4:0] words;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       c;
        logic       last;
        logic [2:0] sum;
        logic       lst;
        logic       cout;
        logic [4:0] words;
        logic       ovf;
    } vec_t;

    exp_t   q[$];
    exp_t   mon_e;
    vec_t   tv[6];
    int     checks = 0;
    int     errors = 0;

    // Packet-level integer reference model state.
    bit     m_first = 1'b1;
    longint m_a, m_b;
    int     m_c0, m_k;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic model_cin(input logic c);
        longint t;
        t = (m_a + m_b + longint'(m_c0)) >> (3 * m_k);
        return m_first ? c : t[0];
    endfunction

    task automatic model_accept(input logic [2:0] a, input logic [2:0] b,
                                input logic c, input logic last);
        exp_t   e;
        longint tot, s;
        bit     forced;
        if (m_first) begin
            m_a  = 0;
            m_b  = 0;
            m_c0 = int'(c);
            m_k  = 0;
        end
        m_a   = m_a | (longint'(a) << (3 * m_k));
        m_b   = m_b | (longint'(b) << (3 * m_k));
        tot   = m_a + m_b + longint'(m_c0);
        s     = tot >> (3 * m_k);
        e.sum = s[2:0];
        m_k++;
        forced  = !last && (m_k == MAX_WORDS);
        e.last  = last || forced;
        s       = tot >> (3 * m_k);
        e.cout  = e.last && s[0];
        e.trunc = forced;
        e.words = 5'(m_k);
        e.ovf   = e.last && (a[2] == b[2]) && (e.sum[2] != a[2]);
        m_first = e.last;
        q.push_back(e);
    endtask

    task automatic drive_word(input logic [2:0] a, input logic [2:0] b,
                              input logic c, input logic last);
        bit done = 1'b0;
        i_a = a; i_b = b; i_c = c; i_last = last; i_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (o_ready) begin
                chk("add_c", 64'(add_c), 64'(model_cin(c)));
                model_accept(a, b, c, last);
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (!done) i_ready = 1'b1;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(posedge clk); #1;
        i_rst   = 1'b0;
        q.delete();
        m_first = 1'b1;
    endtask

    // Scoreboard: compare each transferred output word against the model.
    always @(negedge clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("sb_sum",   64'(o_sum),   64'(mon_e.sum));
                chk("sb_last",  64'(o_last),  64'(mon_e.last));
                chk("sb_cout",  64'(o_cout),  64'(mon_e.cout));
                chk("sb_trunc", 64'(o_trunc), 64'(mon_e.trunc));
                chk("sb_words", 64'(o_words), 64'(mon_e.words));
`ifdef RCA_SERIAL_OVF_EN
                chk("sb_ovf",   64'(o_ovf),   64'(mon_e.ovf));
`endif
            end
        end
    end

    initial begin
        tv[0] = '{3'd7, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 1'b0};
        tv[1] = '{3'd7, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 5'd2, 1'b0};
        tv[2] = '{3'd3, 3'd1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 5'd1, 1'b1};
        tv[3] = '{3'd5, 3'd6, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 5'd1, 1'b1};
        tv[4] = '{3'd2, 3'd2, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 5'd1, 1'b0};
        tv[5] = '{3'd6, 3'd3, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 5'd2, 1'b0};

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_a = 3'd0; i_b = 3'd0; i_c = 1'b0; i_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_sum",   64'(o_sum),   64'd0);
        chk("rst_last",  64'(o_last),  64'd0);
        chk("rst_cout",  64'(o_cout),  64'd0);
        chk("rst_trunc", 64'(o_trunc), 64'd0);
        chk("rst_words", 64'(o_words), 64'd0);
`ifdef RCA_SERIAL_OVF_EN
        chk("rst_ovf",   64'(o_ovf),   64'd0);
`endif

        // Directed vectors, one beat each at full rate.
        for (int i = 0; i < 6; i++) begin
            drive_word(tv[i].a, tv[i].b, tv[i].c, tv[i].last);
            chk("tv_valid", 64'(o_valid), 64'd1);
            chk("tv_sum",   64'(o_sum),   64'(tv[i].sum));
            chk("tv_last",  64'(o_last),  64'(tv[i].lst));
            chk("tv_cout",  64'(o_cout),  64'(tv[i].cout));
            chk("tv_words", 64'(o_words), 64'(tv[i].words));
`ifdef RCA_SERIAL_OVF_EN
            chk("tv_ovf",   64'(o_ovf),   64'(tv[i].ovf));
`endif
        end
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: output held for three cycles with a pending input word.
        i_ready = 1'b0;
        drive_word(3'd1, 3'd2, 1'b0, 1'b0);
        i_a = 3'd2; i_b = 3'd3; i_c = 1'b0; i_last = 1'b1; i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", 64'(o_ready), 64'd0);
            chk("bp_valid", 64'(o_valid), 64'd1);
            chk("bp_sum",   64'(o_sum),   64'd3);
            chk("bp_words", 64'(o_words), 64'd1);
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        drive_word(3'd2, 3'd3, 1'b0, 1'b1);
        chk("bp_sum2", 64'(o_sum), 64'd5);
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full-length packet ends normally; an over-long one is force-terminated.
        for (int i = 0; i < MAX_WORDS; i++) begin
            drive_word(3'(i), 3'd3, 1'b0, i == MAX_WORDS - 1);
        end
        chk("full_last",  64'(o_last),  64'd1);
        chk("full_trunc", 64'(o_trunc), 64'd0);
        chk("full_words", 64'(o_words), 64'd16);
        for (int i = 0; i < MAX_WORDS; i++) begin
            drive_word(3'd7, 3'd0, 1'b0, 1'b0);
        end
        chk("trunc_last",  64'(o_last),  64'd1);
        chk("trunc_trunc", 64'(o_trunc), 64'd1);
        chk("trunc_words", 64'(o_words), 64'd16);
        drive_word(3'd1, 3'd1, 1'b1, 1'b1);
        chk("after_trunc_sum",   64'(o_sum),   64'd3);
        chk("after_trunc_words", 64'(o_words), 64'd1);
        chk("after_trunc_trunc", 64'(o_trunc), 64'd0);
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-packet with the carry register set.
        drive_word(3'd7, 3'd1, 1'b0, 1'b0);
        drive_word(3'd7, 3'd7, 1'b0, 1'b0);
        do_reset();
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_words", 64'(o_words), 64'd0);
        drive_word(3'd1, 3'd1, 1'b0, 1'b1);
        chk("mid_rst_sum",  64'(o_sum),  64'd2);
        chk("mid_rst_cout", 64'(o_cout), 64'd0);
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Random packets of 1..8 words with random downstream stalls.
        for (int p = 0; p < 25; p++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int w = 0; w < n; w++) begin
                i_ready = ($urandom_range(0, 3) != 0);
                drive_word(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                           1'($urandom_range(0, 1)), w == n - 1);
            end
            i_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                i_ready = ($urandom_range(0, 1) != 0);
            end
        end

        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
